// File: rtl/sysctrl_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sysctrl_gen_if                                               |
// | Description : MCU link byte stream (strobe/start/data in, data out).       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface sysctrl_gen_if;
  logic       data_in_strobe;
  logic       data_in_start;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (
    output data_in_strobe,
    output data_in_start,
    output data_in,
    input  data_out
  );

  modport slave (
    input  data_in_strobe,
    input  data_in_start,
    input  data_in,
    output data_out
  );
endinterface
`default_nettype wire

// File: rtl/sysctrl_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sysctrl_gen                                                  |
// | Description : MCU system-control slave: framed command decoder driving     |
// |               status, LEDs, RGB, buttons, interrupts, resets and an        |
// |               indexed config bank. Optional macro SYSCTRL_CFG_READBACK_EN  |
// |               enables command 7 config readback.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sysctrl_gen #(
  parameter logic [7:0]           CORE_ID       = 8'h03,
  parameter int                   NUM_CFG       = 16,
  parameter logic [NUM_CFG*8-1:0] CFG_DEFAULT   = '0,
  parameter int                   NUM_LEDS      = 2,
  parameter int                   NUM_BUTTONS   = 2,
  parameter int                   RESET_TIMEOUT = 80_000_000
) (
  input  wire logic                   clk,
  input  wire logic                   reset_n,
  sysctrl_gen_if.slave                mcu,
  output logic                        int_out_n,
  input  wire logic [7:0]             int_in,
  output logic [7:0]                  int_ack,
  input  wire logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_LEDS-1:0]         leds,
  output logic [23:0]                 color,
  output logic [1:0]                  sys_reset,
  output logic                        cold_boot,
  output logic [NUM_CFG*8-1:0]        cfg,
  output logic                        cfg_wr_stb,
  output logic [7:0]                  cfg_wr_idx
);

  localparam int            TW             = (RESET_TIMEOUT == 0) ? 1 : $clog2(RESET_TIMEOUT + 1);
  localparam int            IW             = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam logic [TW-1:0] C_TIMEOUT_INIT = TW'(RESET_TIMEOUT);
  localparam logic [TW-1:0] C_TIMEOUT_ONE  = TW'(1);
  localparam logic [8:0]    C_NUM_CFG      = 9'(NUM_CFG);
  localparam logic [3:0]    C_STATE_IDLE   = 4'd0;
  localparam logic [3:0]    C_STATE_MAX    = 4'd15;

  localparam logic [7:0] C_CMD_STATUS  = 8'h00;
  localparam logic [7:0] C_CMD_LEDS    = 8'h01;
  localparam logic [7:0] C_CMD_COLOR   = 8'h02;
  localparam logic [7:0] C_CMD_BUTTONS = 8'h03;
  localparam logic [7:0] C_CMD_CFG_WR  = 8'h04;
  localparam logic [7:0] C_CMD_INT     = 8'h05;
  localparam logic [7:0] C_CMD_COLD    = 8'h06;
  localparam logic [7:0] C_CMD_RESET   = 8'h08;
  localparam logic [7:0] C_CMD_MASK    = 8'h09;
`ifdef SYSCTRL_CFG_READBACK_EN
  localparam logic [7:0] C_CMD_CFG_RD  = 8'h07;
`endif

  logic [7:0]          r_command;
  logic [3:0]          r_state;
  logic [7:0]          r_cfg_idx;
  logic [7:0]          r_data_out;
  logic [NUM_LEDS-1:0] r_leds;
  logic [23:0]         r_color;
  logic [1:0]          r_sys_reset;
  logic                r_cold_boot;
  logic                r_sys_int;
  logic [7:0]          r_int_ack;
  logic [7:0]          r_int_mask;
  logic [7:0]          r_cfg [NUM_CFG];
  logic                r_cfg_wr_stb;
  logic [7:0]          r_cfg_wr_idx;
  logic [TW-1:0]       r_timeout;

  logic [7:0]          w_buttons_ext;
  logic                w_idx_ok;
  logic [IW-1:0]       w_idx_sel;

  function automatic logic [7:0] f_rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  always_comb begin
    w_buttons_ext                  = '0;
    w_buttons_ext[NUM_BUTTONS-1:0] = buttons;
  end

  assign w_idx_ok  = ({1'b0, r_cfg_idx} < C_NUM_CFG);
  assign w_idx_sel = r_cfg_idx[IW-1:0];

`ifdef SYSCTRL_CFG_READBACK_EN
  logic          w_rd_ok;
  logic [IW-1:0] w_rd_sel;
  assign w_rd_ok  = ({1'b0, mcu.data_in} < C_NUM_CFG);
  assign w_rd_sel = mcu.data_in[IW-1:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_command    <= 8'h00;
      r_state      <= C_STATE_IDLE;
      r_cfg_idx    <= 8'h00;
      r_data_out   <= 8'h00;
      r_leds       <= '0;
      r_color      <= 24'h000000;
      r_sys_reset  <= 2'd3;
      r_cold_boot  <= 1'b1;
      r_sys_int    <= 1'b1;
      r_int_ack    <= 8'h00;
      r_int_mask   <= 8'hFF;
      r_cfg_wr_stb <= 1'b0;
      r_cfg_wr_idx <= 8'h00;
      r_timeout    <= C_TIMEOUT_INIT;
      for (int i = 0; i < NUM_CFG; i++) r_cfg[i] <= CFG_DEFAULT[8*i +: 8];
    end else begin
      r_int_ack    <= 8'h00;
      r_cfg_wr_stb <= 1'b0;
      if (r_int_ack[0]) r_sys_int <= 1'b0;

      // Expiry is evaluated first so a same-cycle command write overrides it.
      if (r_timeout != '0) begin
        r_timeout <= r_timeout - C_TIMEOUT_ONE;
        if (r_timeout == C_TIMEOUT_ONE) begin
          r_sys_reset <= 2'd0;
          r_color     <= 24'h000202;
        end
      end

      if (mcu.data_in_strobe && mcu.data_in_start) begin
        r_command <= mcu.data_in;
        r_state   <= 4'd1;
      end else if (mcu.data_in_strobe && (r_state != C_STATE_IDLE)) begin
        if (r_state != C_STATE_MAX) r_state <= r_state + 4'd1;
        case (r_command)
          C_CMD_STATUS: begin
            case (r_state)
              4'd1:    r_data_out <= 8'h5C;
              4'd2:    r_data_out <= 8'h42;
              4'd3:    r_data_out <= CORE_ID;
              default: r_data_out <= 8'h00;
            endcase
          end
          C_CMD_LEDS: begin
            if (r_state == 4'd1) r_leds <= mcu.data_in[NUM_LEDS-1:0];
          end
          C_CMD_COLOR: begin
            case (r_state)
              4'd1:    r_color[15:8]  <= f_rev8(mcu.data_in);
              4'd2:    r_color[7:0]   <= f_rev8(mcu.data_in);
              4'd3:    r_color[23:16] <= f_rev8(mcu.data_in);
              default: ;
            endcase
          end
          C_CMD_BUTTONS: r_data_out <= w_buttons_ext;
          C_CMD_CFG_WR: begin
            if (r_state == 4'd1) begin
              r_cfg_idx <= mcu.data_in;
            end else if ((r_state == 4'd2) && w_idx_ok) begin
              r_cfg[w_idx_sel] <= mcu.data_in;
              r_cfg_wr_idx     <= r_cfg_idx;
              r_cfg_wr_stb     <= 1'b1;
            end
          end
          C_CMD_INT: begin
            if (r_state == 4'd1) r_int_ack <= mcu.data_in;
            r_data_out <= {int_in[7:1], r_sys_int};
          end
          C_CMD_COLD: begin
            r_data_out <= {7'b0, r_cold_boot};
            if (r_state == 4'd1) r_cold_boot <= 1'b0;
          end
`ifdef SYSCTRL_CFG_READBACK_EN
          C_CMD_CFG_RD: begin
            if (r_state == 4'd1) r_data_out <= w_rd_ok ? r_cfg[w_rd_sel] : 8'hFF;
            else                 r_data_out <= r_cfg_wr_idx;
          end
`endif
          C_CMD_RESET: begin
            if (r_state == 4'd1) begin
              r_sys_reset <= mcu.data_in[1:0];
              r_timeout   <= '0;
            end
          end
          C_CMD_MASK: begin
            if (r_state == 4'd1) r_int_mask <= mcu.data_in;
          end
          default: ;
        endcase
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
      assign cfg[8*g +: 8] = r_cfg[g];
    end
  endgenerate

  assign mcu.data_out = r_data_out;
  assign int_out_n    = !((|(int_in & r_int_mask)) | r_sys_int);
  assign int_ack      = r_int_ack;
  assign leds         = r_leds;
  assign color        = r_color;
  assign sys_reset    = r_sys_reset;
  assign cold_boot    = r_cold_boot;
  assign cfg_wr_stb   = r_cfg_wr_stb;
  assign cfg_wr_idx   = r_cfg_wr_idx;

endmodule
`default_nettype wire

// File: tb/tb_sysctrl_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sysctrl_gen                                               |
// | Description : Scoreboard bench for sysctrl_gen, directed byte frames.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sysctrl_gen;

  localparam logic [127:0] C_CFG_DEF = 128'hC300_0000_0000_0000_0000_0000_0000_005A;

  localparam int S_DOUT = 0, S_LEDS = 1, S_COLOR = 2, S_SYSRST = 3, S_COLD = 4;
  localparam int S_INTN = 5, S_ACK = 6, S_STB = 7, S_WIDX = 8, S_CFG = 9;

  typedef struct {
    int          cyc;
    int          sel;
    int          arg;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  logic         clk;
  logic         reset_n;
  logic         int_out_n;
  logic [7:0]   int_in;
  logic [7:0]   int_ack;
  logic [1:0]   buttons;
  logic [1:0]   leds;
  logic [23:0]  color;
  logic [1:0]   sys_reset;
  logic         cold_boot;
  logic [127:0] cfg;
  logic         cfg_wr_stb;
  logic [7:0]   cfg_wr_idx;

  sysctrl_gen_if bus ();

  sysctrl_gen #(
    .CORE_ID       (8'h03),
    .NUM_CFG       (16),
    .CFG_DEFAULT   (C_CFG_DEF),
    .NUM_LEDS      (2),
    .NUM_BUTTONS   (2),
    .RESET_TIMEOUT (10)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mcu        (bus),
    .int_out_n  (int_out_n),
    .int_in     (int_in),
    .int_ack    (int_ack),
    .buttons    (buttons),
    .leds       (leds),
    .color      (color),
    .sys_reset  (sys_reset),
    .cold_boot  (cold_boot),
    .cfg        (cfg),
    .cfg_wr_stb (cfg_wr_stb),
    .cfg_wr_idx (cfg_wr_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [31:0] get_val(input int sel, input int arg);
    case (sel)
      S_DOUT:   return 32'(bus.data_out);
      S_LEDS:   return 32'(leds);
      S_COLOR:  return 32'(color);
      S_SYSRST: return 32'(sys_reset);
      S_COLD:   return 32'(cold_boot);
      S_INTN:   return 32'(int_out_n);
      S_ACK:    return 32'(int_ack);
      S_STB:    return 32'(cfg_wr_stb);
      S_WIDX:   return 32'(cfg_wr_idx);
      S_CFG:    return 32'(cfg[8*arg +: 8]);
      default:  return 32'hDEADBEEF;
    endcase
  endfunction

  // Monitor: samples just after each rising edge and retires due expectations.
  always @(posedge clk) begin
    logic [31:0] act;
    #1;
    cyc++;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        act = get_val(q[i].sel, q[i].arg);
        n_tests++;
        if (q[i].cyc < cyc || act !== q[i].exp) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h (cycle %0d, due %0d)",
                   q[i].nm, act, q[i].exp, cyc, q[i].cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic expect_at(input int t, input int sel, input int arg,
                           input logic [31:0] e, input string nm);
    exp_t x;
    x.cyc = t; x.sel = sel; x.arg = arg; x.exp = e; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic send(input logic st, input logic [7:0] d, output int t);
    @(negedge clk);
    bus.data_in_strobe = 1'b1;
    bus.data_in_start  = st;
    bus.data_in        = d;
    t = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.data_in_strobe = 1'b0;
      bus.data_in_start  = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, k;
    bus.data_in_strobe = 1'b0;
    bus.data_in_start  = 1'b0;
    bus.data_in        = 8'h00;
    int_in             = 8'h00;
    buttons            = 2'b10;
    reset_n            = 1'b0;
    idle(3);

    // Reset values, then untouched auto-release after 10 cycles
    @(negedge clk); reset_n = 1'b1; k = cyc;
    expect_at(k+1, S_SYSRST, 0, 32'h3, "rst_sys_reset");
    expect_at(k+1, S_COLD,   0, 32'h1, "rst_cold_boot");
    expect_at(k+1, S_DOUT,   0, 32'h0, "rst_data_out");
    expect_at(k+1, S_LEDS,   0, 32'h0, "rst_leds");
    expect_at(k+1, S_COLOR,  0, 32'h0, "rst_color");
    expect_at(k+1, S_INTN,   0, 32'h0, "rst_int_out_n");
    expect_at(k+1, S_ACK,    0, 32'h0, "rst_int_ack");
    expect_at(k+1, S_STB,    0, 32'h0, "rst_cfg_wr_stb");
    expect_at(k+1, S_WIDX,   0, 32'h0, "rst_cfg_wr_idx");
    expect_at(k+1, S_CFG,    0, 32'h5A, "rst_cfg0");
    expect_at(k+1, S_CFG,   15, 32'hC3, "rst_cfg15");
    expect_at(k+9,  S_SYSRST, 0, 32'h3, "tmo_before");
    expect_at(k+10, S_SYSRST, 0, 32'h0, "tmo_release");
    expect_at(k+10, S_COLOR,  0, 32'h000202, "tmo_color");
    idle(12);

    // Re-reset; CMD8 at cycle 5 cancels the timeout
    @(negedge clk); reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1; k = cyc;
    expect_at(k+1, S_INTN,   0, 32'h0, "rst2_int_out_n");
    expect_at(k+1, S_SYSRST, 0, 32'h3, "rst2_sys_reset");
    idle(2);
    send(1'b1, 8'h08, t);
    send(1'b0, 8'h01, t);
    expect_at(t,    S_SYSRST, 0, 32'h1, "cmd8_sys_reset");
    expect_at(k+11, S_SYSRST, 0, 32'h1, "cmd8_hold_sys_reset");
    expect_at(k+11, S_COLOR,  0, 32'h0, "cmd8_hold_color");
    idle(12);

    // Status bytes
    send(1'b1, 8'h00, t);
    send(1'b0, 8'h11, t); expect_at(t, S_DOUT, 0, 32'h5C, "status1");
    send(1'b0, 8'h22, t); expect_at(t, S_DOUT, 0, 32'h42, "status2");
    send(1'b0, 8'h33, t); expect_at(t, S_DOUT, 0, 32'h03, "status3");
    send(1'b0, 8'h44, t); expect_at(t, S_DOUT, 0, 32'h00, "status4");
    idle(1);

    // Config write in range and out of range
    send(1'b1, 8'h04, t);
    send(1'b0, 8'h05, t);
    send(1'b0, 8'hA7, t);
    expect_at(t,   S_CFG,  5, 32'hA7, "cfgwr_data");
    expect_at(t,   S_STB,  0, 32'h1,  "cfgwr_stb");
    expect_at(t+1, S_STB,  0, 32'h0,  "cfgwr_stb_end");
    expect_at(t,   S_WIDX, 0, 32'h5,  "cfgwr_idx");
    idle(1);
    send(1'b1, 8'h04, t);
    send(1'b0, 8'h20, t);
    send(1'b0, 8'h55, t);
    expect_at(t, S_STB,  0, 32'h0,  "cfgoor_stb");
    expect_at(t, S_CFG,  0, 32'h5A, "cfgoor_cfg0");
    expect_at(t, S_CFG,  5, 32'hA7, "cfgoor_cfg5");
    expect_at(t, S_WIDX, 0, 32'h5,  "cfgoor_idx");
    idle(1);

    // Interrupt ack, status and mask
    send(1'b1, 8'h05, t);
    send(1'b0, 8'h01, t);
    expect_at(t,   S_ACK,  0, 32'h01, "int_ack_pulse");
    expect_at(t,   S_DOUT, 0, 32'h01, "int_status_pending");
    expect_at(t,   S_INTN, 0, 32'h0,  "int_n_still_low");
    expect_at(t+1, S_ACK,  0, 32'h00, "int_ack_end");
    expect_at(t+1, S_INTN, 0, 32'h1,  "int_n_cleared");
    idle(2);
    int_in = 8'h04;
    expect_at(cyc+1, S_INTN, 0, 32'h0, "int_src_pending");
    send(1'b0, 8'h00, t); expect_at(t, S_DOUT, 0, 32'h04, "int_status_src");
    send(1'b1, 8'h09, t);
    send(1'b0, 8'hFB, t); expect_at(t, S_INTN, 0, 32'h1, "int_masked");
    send(1'b1, 8'h09, t);
    send(1'b0, 8'hFF, t); expect_at(t, S_INTN, 0, 32'h0, "int_unmasked");
    idle(1);
    int_in = 8'h00;

    // Abort a colour frame with an LED command
    send(1'b1, 8'h02, t);
    send(1'b0, 8'h80, t); expect_at(t, S_COLOR, 0, 32'h000100, "abort_color");
    send(1'b1, 8'h01, t);
    send(1'b0, 8'h03, t);
    expect_at(t, S_LEDS,  0, 32'h3,      "abort_leds");
    expect_at(t, S_COLOR, 0, 32'h000100, "abort_color_kept");
    send(1'b0, 8'hFF, t); expect_at(t, S_LEDS, 0, 32'h3, "leds_state2_ignored");
    idle(1);

    // Full colour frame, bit-reversed into G/B/R order
    send(1'b1, 8'h02, t);
    send(1'b0, 8'h01, t);
    send(1'b0, 8'h03, t);
    send(1'b0, 8'h0F, t); expect_at(t, S_COLOR, 0, 32'hF080C0, "color_full");
    idle(1);

    // Buttons, then unknown command keeps data_out
    send(1'b1, 8'h03, t);
    send(1'b0, 8'h00, t); expect_at(t, S_DOUT, 0, 32'h02, "buttons");
    send(1'b1, 8'h0A, t);
    send(1'b0, 8'h77, t); expect_at(t, S_DOUT, 0, 32'h02, "unknown_cmd");
    idle(1);

    // Command 7: readback when enabled, otherwise no effect
    send(1'b1, 8'h04, t);
    send(1'b0, 8'h03, t);
    send(1'b0, 8'h3C, t);
    send(1'b1, 8'h07, t);
`ifdef SYSCTRL_CFG_READBACK_EN
    send(1'b0, 8'h03, t); expect_at(t, S_DOUT, 0, 32'h3C, "cmd7_rd");
    send(1'b0, 8'h00, t); expect_at(t, S_DOUT, 0, 32'h03, "cmd7_widx");
    send(1'b1, 8'h07, t);
    send(1'b0, 8'h40, t); expect_at(t, S_DOUT, 0, 32'hFF, "cmd7_oor");
`else
    send(1'b0, 8'h03, t); expect_at(t, S_DOUT, 0, 32'h02, "cmd7_ignored");
    send(1'b0, 8'h00, t); expect_at(t, S_DOUT, 0, 32'h02, "cmd7_ignored2");
    send(1'b1, 8'h07, t);
    send(1'b0, 8'h40, t); expect_at(t, S_DOUT, 0, 32'h02, "cmd7_ignored3");
`endif
    idle(1);

    // Cold boot flag read and clear
    send(1'b1, 8'h06, t);
    send(1'b0, 8'h00, t);
    expect_at(t, S_DOUT, 0, 32'h01, "cold_read");
    expect_at(t, S_COLD, 0, 32'h0,  "cold_clear");
    send(1'b0, 8'h00, t); expect_at(t, S_DOUT, 0, 32'h00, "cold_read2");
    idle(1);

    // Asynchronous reset in the middle of a frame
    send(1'b1, 8'h02, t);
    send(1'b0, 8'hFF, t); expect_at(t, S_COLOR, 0, 32'hF0FFC0, "pre_reset_color");
    idle(1);
    reset_n = 1'b0;
    expect_at(cyc+1, S_COLOR,  0, 32'h0, "midrst_color");
    expect_at(cyc+1, S_SYSRST, 0, 32'h3, "midrst_sys_reset");
    expect_at(cyc+1, S_COLD,   0, 32'h1, "midrst_cold_boot");
    idle(2);
    reset_n = 1'b1;
    send(1'b0, 8'h01, t);
    expect_at(t, S_COLOR, 0, 32'h0, "lost_frame_color");
    expect_at(t, S_LEDS,  0, 32'h0, "lost_frame_leds");
    idle(3);

    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL pending: got %0d unchecked expectations, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
